// File: rtl/hazard_ctrl_pkg.sv
// Shared select codes, Tuse sentinel and multiply/divide latency defaults
// for the MIPS hazard/forwarding scheduler.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_GRF   = 2'd0;
  localparam logic [1:0] FWD_E     = 2'd1;
  localparam logic [1:0] FWD_M     = 2'd2;
  localparam logic [1:0] FWD_W     = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Two-level priority forwarding select: source A (younger) beats source B,
// and register 0 never forwards.
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter logic [1:0] CODE_A = FWD_E,
  parameter logic [1:0] CODE_B = FWD_M
) (
  input  logic [4:0] idx_i,
  input  logic [4:0] a_addr_i,
  input  logic       a_ok_i,
  input  logic [4:0] b_addr_i,
  input  logic       b_ok_i,
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o = FWD_GRF;
    if (idx_i != 5'd0) begin
      if (a_ok_i && (a_addr_i == idx_i))      sel_o = CODE_A;
      else if (b_ok_i && (b_addr_i == idx_i)) sel_o = CODE_B;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding scheduler for the F/D/E/M/W pipeline: tracks E/M/W writers,
// stalls D, selects forwarding paths and times the MD unit. Optional: HAZARD_PERF_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_dst,
  input  logic [1:0] d_tnew,
  input  logic       d_md_use,
  input  logic       d_md_start,
  input  logic       d_md_div,
  output logic       stall,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic       md_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] md_stall_cnt
`endif
);

  localparam int MD_MAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int MD_W   = $clog2(MD_MAX + 1);

  logic [4:0]      e_addr_q, e_rs_q, e_rt_q, m_addr_q, w_addr_q;
  logic [1:0]      e_tnew_q, m_tnew_q, m_tnew_d;
  logic            e_md_start_q, e_md_div_q;
  logic [MD_W-1:0] md_cnt_q, md_cnt_d;
  logic            data_stall_rs, data_stall_rt, data_stall, md_stall;

  // A D operand must wait while a tracked writer still needs more cycles than D can wait.
  assign data_stall_rs = (d_rs != 5'd0) &&
                         (((e_addr_q == d_rs) && (e_tnew_q > d_tuse_rs)) ||
                          ((m_addr_q == d_rs) && (m_tnew_q > d_tuse_rs)));
  assign data_stall_rt = (d_rt != 5'd0) &&
                         (((e_addr_q == d_rt) && (e_tnew_q > d_tuse_rt)) ||
                          ((m_addr_q == d_rt) && (m_tnew_q > d_tuse_rt)));
  assign data_stall    = data_stall_rs || data_stall_rt;
  assign md_stall      = d_md_use && (md_busy || e_md_start_q);
  assign stall         = data_stall || md_stall;
  assign md_busy       = (md_cnt_q != '0);

  assign m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (e_md_start_q)          md_cnt_d = e_md_div_q ? MD_W'(DIV_CYC) : MD_W'(MULT_CYC);
    else if (md_cnt_q != '0)   md_cnt_d = md_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_addr_q     <= '0;
      e_tnew_q     <= '0;
      e_rs_q       <= '0;
      e_rt_q       <= '0;
      e_md_start_q <= 1'b0;
      e_md_div_q   <= 1'b0;
      m_addr_q     <= '0;
      m_tnew_q     <= '0;
      w_addr_q     <= '0;
      md_cnt_q     <= '0;
    end else begin
      e_addr_q     <= stall ? 5'd0 : d_dst;
      e_tnew_q     <= stall ? 2'd0 : d_tnew;
      e_rs_q       <= stall ? 5'd0 : d_rs;
      e_rt_q       <= stall ? 5'd0 : d_rt;
      e_md_start_q <= stall ? 1'b0 : d_md_start;
      e_md_div_q   <= stall ? 1'b0 : d_md_div;
      m_addr_q     <= e_addr_q;
      m_tnew_q     <= m_tnew_d;
      w_addr_q     <= m_addr_q;
      md_cnt_q     <= md_cnt_d;
    end
  end

  hazard_fwd_sel #(.CODE_A(FWD_E), .CODE_B(FWD_M)) u_fwd_d_rs (
    .idx_i(d_rs), .a_addr_i(e_addr_q), .a_ok_i(e_tnew_q == 2'd0),
    .b_addr_i(m_addr_q), .b_ok_i(m_tnew_q == 2'd0), .sel_o(fwd_d_rs));
  hazard_fwd_sel #(.CODE_A(FWD_E), .CODE_B(FWD_M)) u_fwd_d_rt (
    .idx_i(d_rt), .a_addr_i(e_addr_q), .a_ok_i(e_tnew_q == 2'd0),
    .b_addr_i(m_addr_q), .b_ok_i(m_tnew_q == 2'd0), .sel_o(fwd_d_rt));

  // In E the M stage is the younger source (code 1) and W the older one (code 2).
  hazard_fwd_sel #(.CODE_A(2'd1), .CODE_B(FWD_W)) u_fwd_e_rs (
    .idx_i(e_rs_q), .a_addr_i(m_addr_q), .a_ok_i(m_tnew_q == 2'd0),
    .b_addr_i(w_addr_q), .b_ok_i(1'b1), .sel_o(fwd_e_rs));
  hazard_fwd_sel #(.CODE_A(2'd1), .CODE_B(FWD_W)) u_fwd_e_rt (
    .idx_i(e_rt_q), .a_addr_i(m_addr_q), .a_ok_i(m_tnew_q == 2'd0),
    .b_addr_i(w_addr_q), .b_ok_i(1'b1), .sel_o(fwd_e_rt));

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (stall)                     stall_cnt    <= stall_cnt + 32'd1;
      if (md_stall && !data_stall)   md_stall_cnt <= md_stall_cnt + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against a pipeline-of-records
// reference model; prints one summary line.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_use, d_md_start, d_md_div;
  logic       stall, md_busy;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, md_stall_cnt;
  int          exp_stall_cnt, exp_md_stall_cnt;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_tnew(d_tnew), .d_md_use(d_md_use),
    .d_md_start(d_md_start), .d_md_div(d_md_div),
    .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .md_busy(md_busy)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt)
`endif
  );

  // Reference model: one record per in-flight instruction in E, M, W.
  typedef struct {
    int dst;
    int tnew;
    int rs;
    int rt;
    bit md_start;
    bit md_div;
  } instr_t;

  instr_t pipe_e, pipe_m, pipe_w;
  int     md_left;

  function automatic instr_t bubble();
    instr_t b;
    b.dst = 0; b.tnew = 0; b.rs = 0; b.rt = 0; b.md_start = 0; b.md_div = 0;
    return b;
  endfunction

  function automatic bit waits_on(int idx, int tuse);
    if (idx == 0) return 0;
    return (pipe_e.dst == idx && pipe_e.tnew > tuse) ||
           (pipe_m.dst == idx && pipe_m.tnew > tuse);
  endfunction

  function automatic int d_source(int idx);
    if (idx == 0) return 0;
    if (pipe_e.dst == idx && pipe_e.tnew == 0) return 1;
    if (pipe_m.dst == idx && pipe_m.tnew == 0) return 2;
    return 0;
  endfunction

  function automatic int e_source(int idx);
    if (idx == 0) return 0;
    if (pipe_m.dst == idx && pipe_m.tnew == 0) return 1;
    if (pipe_w.dst == idx) return 2;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_d(input int rs, input int rt, input int tuse_rs, input int tuse_rt,
                       input int dst, input int tnew, input bit mu, input bit ms, input bit mdv);
    d_rs = 5'(rs); d_rt = 5'(rt); d_tuse_rs = 2'(tuse_rs); d_tuse_rt = 2'(tuse_rt);
    d_dst = 5'(dst); d_tnew = 2'(tnew); d_md_use = mu; d_md_start = ms; d_md_div = mdv;
  endtask

  task automatic idle_d();
    set_d(0, 0, 3, 3, 0, 0, 0, 0, 0);
  endtask

  // Check all outputs for the current cycle, then advance DUT and model by one edge.
  task automatic cycle();
    bit     exp_md_stall, exp_data_stall, exp_stall;
    instr_t d_ins;
    #1;
    exp_data_stall = waits_on(int'(d_rs), int'(d_tuse_rs)) || waits_on(int'(d_rt), int'(d_tuse_rt));
    exp_md_stall   = d_md_use && (md_left != 0 || pipe_e.md_start);
    exp_stall      = exp_data_stall || exp_md_stall;
    chk("stall",    32'(stall),    32'(exp_stall));
    chk("md_busy",  32'(md_busy),  32'(md_left != 0));
    chk("fwd_d_rs", 32'(fwd_d_rs), 32'(d_source(int'(d_rs))));
    chk("fwd_d_rt", 32'(fwd_d_rt), 32'(d_source(int'(d_rt))));
    chk("fwd_e_rs", 32'(fwd_e_rs), 32'(e_source(pipe_e.rs)));
    chk("fwd_e_rt", 32'(fwd_e_rt), 32'(e_source(pipe_e.rt)));
`ifdef HAZARD_PERF_EN
    chk("stall_cnt",    stall_cnt,    32'(exp_stall_cnt));
    chk("md_stall_cnt", md_stall_cnt, 32'(exp_md_stall_cnt));
`endif
    d_ins.dst = int'(d_dst); d_ins.tnew = int'(d_tnew); d_ins.rs = int'(d_rs);
    d_ins.rt = int'(d_rt); d_ins.md_start = d_md_start; d_ins.md_div = d_md_div;
    @(posedge clk);
    if (reset) begin
      pipe_e = bubble(); pipe_m = bubble(); pipe_w = bubble(); md_left = 0;
`ifdef HAZARD_PERF_EN
      exp_stall_cnt = 0; exp_md_stall_cnt = 0;
`endif
    end else begin
`ifdef HAZARD_PERF_EN
      if (exp_stall) exp_stall_cnt++;
      if (exp_md_stall && !exp_data_stall) exp_md_stall_cnt++;
`endif
      if (pipe_e.md_start) md_left = pipe_e.md_div ? 10 : 5;
      else if (md_left > 0) md_left--;
      pipe_w = pipe_m; pipe_w.tnew = 0;
      pipe_m = pipe_e; pipe_m.tnew = (pipe_e.tnew > 0) ? pipe_e.tnew - 1 : 0;
      pipe_e = exp_stall ? bubble() : d_ins;
    end
    @(negedge clk);
  endtask

  initial begin
    pipe_e = bubble(); pipe_m = bubble(); pipe_w = bubble(); md_left = 0;
`ifdef HAZARD_PERF_EN
    exp_stall_cnt = 0; exp_md_stall_cnt = 0;
`endif
    reset = 1'b1;
    idle_d();
    repeat (2) @(posedge clk);
    @(negedge clk);
    cycle();                                 // reset state, reset still asserted
    reset = 1'b0;
    cycle();

    // lw $1 then add reading $1 with tuse=1: stall, then resolve
    set_d(0, 0, 3, 3, 1, 2, 0, 0, 0); cycle();
    set_d(1, 2, 1, 1, 3, 1, 0, 0, 0); cycle();
    cycle();
    idle_d(); cycle(); cycle();

    // jal $31 in E with tnew=0, jr $31 with tuse=0 -> forward from E
    set_d(0, 0, 3, 3, 31, 0, 0, 0, 0); cycle();
    set_d(31, 0, 0, 3, 0, 0, 0, 0, 0); cycle();
    idle_d(); cycle();

    // addu $5 in W and M, reader of $5 in E: M wins, then W alone
    set_d(0, 0, 3, 3, 5, 1, 0, 0, 0); cycle();
    set_d(0, 0, 3, 3, 5, 1, 0, 0, 0); cycle();
    set_d(5, 5, 1, 1, 6, 1, 0, 0, 0); cycle();
    idle_d(); cycle();
    set_d(0, 0, 3, 3, 5, 1, 0, 0, 0); cycle();
    set_d(0, 0, 3, 3, 7, 1, 0, 0, 0); cycle();
    set_d(5, 0, 1, 3, 8, 1, 0, 0, 0); cycle();
    idle_d(); cycle(); cycle(); cycle();

    // writer to $0 with tnew=2, D reads $0 -> no stall, no forward
    set_d(0, 0, 3, 3, 0, 2, 0, 0, 0); cycle();
    set_d(0, 0, 0, 0, 9, 1, 0, 0, 0); cycle();
    idle_d(); cycle();

    // div through E, then mflo waits for the full busy window
    set_d(2, 3, 1, 1, 0, 0, 1, 1, 1); cycle();
    set_d(0, 0, 3, 3, 4, 1, 1, 0, 0);
    repeat (13) cycle();
    idle_d(); cycle();

    // mult latency window
    set_d(2, 3, 1, 1, 0, 0, 1, 1, 0); cycle();
    set_d(0, 0, 3, 3, 4, 1, 1, 0, 0);
    repeat (8) cycle();
    idle_d(); cycle();

    // reset during a div busy window with lw in E
    set_d(2, 3, 1, 1, 0, 0, 1, 1, 1); cycle();
    set_d(0, 0, 3, 3, 4, 2, 0, 0, 0); cycle();
    set_d(4, 0, 1, 3, 0, 0, 1, 0, 0); reset = 1'b1; cycle();
    reset = 1'b0; cycle();
    idle_d(); cycle();

    // randomized traffic over a small register window so hazards are frequent
    for (int i = 0; i < 600; i++) begin
      bit ms, mu;
      ms = ($urandom_range(0, 14) == 0);
      mu = ms || ($urandom_range(0, 5) == 0);
      set_d($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 2),
            mu, ms, $urandom_range(0, 1));
      reset = ($urandom_range(0, 59) == 0);
      cycle();
    end
    reset = 1'b0;
    idle_d();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard and forwarding scheduler for the 5-stage MIPS pipeline (F/D/E/M/W).
- Tracks the destination register and Tnew of every in-flight writer in E, M and W.
- Arbitrates general-register-file read values between the file itself and the forwarding paths.
- Issues D-stage stall/bubble and sequences the multiply/divide unit's busy window.

Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu start
- DIV_CYC, 10, busy cycles after a div/divu start

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- d_rs  in  5  D-stage rs index
- d_rt  in  5  D-stage rt index
- d_tuse_rs  in  2  cycles until rs is needed (3 = unused)
- d_tuse_rt  in  2  cycles until rt is needed (3 = unused)
- d_dst  in  5  D-stage destination (0 = none)
- d_tnew  in  2  Tnew of the D instruction on E entry
- d_md_use  in  1  D instruction uses the MD unit or HI/LO
- d_md_start  in  1  D instruction starts mult/div
- d_md_div  in  1  start is a divide
- stall  out  1  freeze F/D, bubble into E
- fwd_d_rs  out  2  0 GRF, 1 E-stage value, 2 M-stage value
- fwd_d_rt  out  2  same encoding
- fwd_e_rs  out  2  0 ID/EX value, 1 M-stage value, 2 W-stage value
- fwd_e_rt  out  2  same encoding
- md_busy  out  1  MD unit busy

Behaviour:
- Tracking registers per stage: addr[4:0], tnew[1:0]; E stage also holds rs, rt and md_start.
- All tracking registers, the MD counter and all outputs are 0 after reset.
- Reset asserted mid-operation drops all in-flight state on that edge. No stall is held over.
- Advance on each clk edge:
  - stall=0: E loads the D fields.
  - stall=1: E loads a bubble (all zero).
  - M <= E with tnew = sat(E.tnew-1), floor 0.
  - W <= M with tnew = 0.
- Stall is combinational. For X in {rs, rt} with d_X != 0, stall if either:
  - E.addr==d_X && E.tnew > d_tuse_X
  - M.addr==d_X && M.tnew > d_tuse_X
- MD stall: also stall if d_md_use && (md_busy || E.md_start).
- Register 0 never stalls and is never forwarded.
- D forwarding, per operand:
  - E.addr==idx && E.tnew==0 -> 1
  - else M.addr==idx && M.tnew==0 -> 2
  - else 0
  - The youngest writer wins. W-to-D is covered by the register file's same-cycle write bypass, so there is no W path to D.
- E forwarding, per operand:
  - M.addr==E.idx && M.tnew==0 -> 1
  - else W.addr==E.idx -> 2
  - else 0
  - idx==0 -> 0
- MD counter:
  - When E.md_start at an edge, the counter loads DIV_CYC if div, else MULT_CYC.
  - Otherwise it decrements while nonzero.
  - md_busy = (counter != 0).
  - A new start while busy cannot occur, because it is stalled in D.
- Simultaneous events: stall and E.md_start in the same cycle advance E normally. The bubble enters E, and the counter loads from the departing E.
- Outputs are purely combinational from the tracking state and D inputs. There is no output latency beyond that.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - Adds two outputs: stall_cnt (32b) and md_stall_cnt (32b).
  - stall_cnt increments on every cycle with stall=1.
  - md_stall_cnt increments only on cycles where the MD condition alone causes the stall.
  - Both counters are cleared by reset and wrap at 2^32.
- Not defined: the ports and counters are absent, and there is no other change.

Decomposition:
- Shared package/def file:
  - FWD_GRF=0, FWD_E=1, FWD_M=2, FWD_W=2 select codes
  - TUSE_NONE=3
  - MULT_CYC and DIV_CYC defaults
- Sub-module hazard_fwd_sel: combinational priority forwarding-select logic, instantiated 4 times (D rs/rt, E rs/rt).

Test Plan:
- lw $1 in E (tnew=2), D: add reading $1 with tuse=1 -> stall=1. Next cycle, with M.tnew=1 > 1 false -> stall=0 and fwd_d_rs=2 once M.tnew==0.
- jal writing $31 in E (tnew=0), D: jr $31 with tuse=0 -> stall=0, fwd_d_rs=1.
- addu $5 in M (tnew=0) and addu $5 in W, E instruction reads $5 -> fwd_e_rs=1 (M priority). With M.addr≠5 -> 2.
- Writer to $0 with tnew=2, D reads $0 -> stall=0, all fwd=0.
- div starts through E, then mflo in D -> md_busy=1 for 10 cycles and stall=1 throughout. The stall releases on the cycle md_busy falls.
- Reset asserted during a div busy window with a lw in E -> next cycle md_busy=0, stall=0, all fwd=0.
